// File: rtl/bepu_pkg.sv
// Shared constants and types for the back-end peripheral unit (LED + 7-segment).
package bepu_pkg;

    // Bit positions inside the one-hot chip-select bus
    localparam int SEL_LED = 0;
    localparam int SEL_HEX = 1;
    localparam int SEL_CTL = 2;

    // Active-low idle patterns for cathodes and anodes
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    // One registered display slot: anode vector plus cathode vector {dp,g,f,e,d,c,b,a}
    typedef struct packed {
        logic [7:0] an;
        logic [7:0] cat;
    } seg_out_t;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high seven-segment pattern (bit order gfedcba).
module seg7_decode (
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    // Pure lookup; lower-case b and d so they differ from 8 and 0
    always_comb begin
        pattern = 7'h00;
        unique case (nibble)
            4'h0: pattern = 7'h3F;
            4'h1: pattern = 7'h06;
            4'h2: pattern = 7'h5B;
            4'h3: pattern = 7'h4F;
            4'h4: pattern = 7'h66;
            4'h5: pattern = 7'h6D;
            4'h6: pattern = 7'h7D;
            4'h7: pattern = 7'h07;
            4'h8: pattern = 7'h7F;
            4'h9: pattern = 7'h6F;
            4'hA: pattern = 7'h77;
            4'hB: pattern = 7'h7C;
            4'hC: pattern = 7'h39;
            4'hD: pattern = 7'h5E;
            4'hE: pattern = 7'h79;
            4'hF: pattern = 7'h71;
        endcase
    end

endmodule

// File: rtl/bepu_led_segment.sv
// LED register, hex display register and display-control register written from
// the CPU store bus, plus an 8-digit time-multiplexed seven-segment scanner.
//
// Write bus protocol: there is no valid/ready pair. bepu_w acts as the valid
// qualifier for bepu_sel/bepu_data and is sampled on every rising edge; this
// block is always ready, so a held strobe simply rewrites the same value.
module bepu_led_segment
    import bepu_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int LED_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      bepu_sel,
    input  logic             bepu_w,
    input  logic [31:0]      bepu_data,
    input  logic [31:0]      bepu_addr,
    output logic [LED_W-1:0] led,
    output logic [7:0]       seg_an,
    output logic [7:0]       seg_cat
);

    localparam int             PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);

    logic [LED_W-1:0] led_reg;
    logic [31:0]      hex_reg;
    logic [15:0]      ctl_reg;
    logic [PW-1:0]    prescaler;
    logic [2:0]       digit_idx;
    logic             scan_wrap;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_pattern;
    seg_out_t         seg_next;
    seg_out_t         seg_q;

    // Address and upper select lines carry no meaning here
    logic unused_bus;
    assign unused_bus = ^{bepu_addr, bepu_sel[31:3]};

    // Register bank: every selected register takes the store in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_reg <= '0;
            hex_reg <= '0;
            ctl_reg <= '0;
        end else if (bepu_w) begin
            if (bepu_sel[SEL_LED]) led_reg <= bepu_data[LED_W-1:0];
            if (bepu_sel[SEL_HEX]) hex_reg <= bepu_data;
            if (bepu_sel[SEL_CTL]) ctl_reg <= bepu_data[15:0];
        end
    end

    assign scan_wrap = (prescaler == PRE_LAST);

    // Prescaler and digit index; index steps on the prescaler wrap cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler <= '0;
            digit_idx <= '0;
        end else if (scan_wrap) begin
            prescaler <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    assign cur_nibble = hex_reg[{digit_idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble  (cur_nibble),
        .pattern (cur_pattern)
    );

    // Next pin values from the current index; a blanked digit keeps its anode slot
    always_comb begin
        seg_next.an  = ~(8'b1 << digit_idx);
        seg_next.cat = {~ctl_reg[{1'b1, digit_idx}], ~cur_pattern};
        if (ctl_reg[digit_idx]) begin
            seg_next.cat = SEG_BLANK;
        end
    end

    // Output register so index changes and register writes land on pins together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_q.an  <= AN_OFF;
            seg_q.cat <= SEG_BLANK;
        end else begin
            seg_q <= seg_next;
        end
    end

    assign led     = led_reg;
    assign seg_an  = seg_q.an;
    assign seg_cat = seg_q.cat;

endmodule

// File: tb/tb_bepu_led_segment.sv
// Bench for bepu_led_segment: directed scenarios plus random store traffic,
// a cycle-based reference model feeding an expected queue, and a monitor.
module tb_bepu_led_segment;

    localparam int SCAN_DIV = 4;
    localparam int LED_W    = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bepu_sel  = '0;
    logic        bepu_w    = 1'b0;
    logic [31:0] bepu_data = '0;
    logic [31:0] bepu_addr = '0;
    logic [LED_W-1:0] led;
    logic [7:0]  seg_an;
    logic [7:0]  seg_cat;

    always #5 clk = ~clk;

    bepu_led_segment #(
        .SCAN_DIV (SCAN_DIV),
        .LED_W    (LED_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bepu_sel  (bepu_sel),
        .bepu_w    (bepu_w),
        .bepu_data (bepu_data),
        .bepu_addr (bepu_addr),
        .led       (led),
        .seg_an    (seg_an),
        .seg_cat   (seg_cat)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // Reference model: registers plus edges elapsed since reset release
    int          n_m   = 0;
    logic [15:0] led_m = '0;
    logic [31:0] hex_m = '0;
    logic [15:0] ctl_m = '0;
    logic [15:0] disp_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg7_ref(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;  4'h1: return 7'h06;
            4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;
            4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;
            4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;
            4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Digit shown n edges after reset: slot = floor(n / SCAN_DIV) mod 8
    function automatic logic [15:0] disp_ref(input int n, input logic [31:0] hex,
                                             input logic [15:0] ctl);
        int k;
        logic [7:0] an;
        logic [7:0] cat;
        k = (n / SCAN_DIV) % 8;
        an = 8'hFF;
        an[k] = 1'b0;
        if (ctl[k]) cat = 8'hFF;
        else        cat = {~ctl[8 + k], ~seg7_ref(hex[4 * k +: 4])};
        return {an, cat};
    endfunction

    // Model: pins after this edge show the display of the pre-edge state,
    // while led follows the register written at this edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            n_m   = 0;
            led_m = '0;
            hex_m = '0;
            ctl_m = '0;
        end else begin
            disp_exp = disp_ref(n_m, hex_m, ctl_m);
            if (bepu_w) begin
                if (bepu_sel[0]) led_m = bepu_data[15:0];
                if (bepu_sel[1]) hex_m = bepu_data;
                if (bepu_sel[2]) ctl_m = bepu_data[15:0];
            end
            exp_q.push_back({led_m, disp_exp});
            n_m++;
        end
    end

    // Monitor: compare pins against the oldest expectation each cycle
    always @(negedge clk) begin
        logic [31:0] want;
        if (!rst) begin
            check("reset_pins", {led, seg_an, seg_cat}, {16'h0000, 8'hFF, 8'hFF});
        end else if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("scan_pins", {led, seg_an, seg_cat}, want);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    task automatic store(input logic [31:0] sel, input logic [31:0] data);
        @(negedge clk);
        bepu_sel  = sel;
        bepu_data = data;
        bepu_w    = 1'b1;
        @(negedge clk);
        bepu_w    = 1'b0;
        bepu_sel  = '0;
        bepu_data = '0;
    endtask

    // Wait (bounded) until the given anode pattern is on the pins
    task automatic wait_an(input logic [7:0] an, output logic found);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (seg_an == an) found = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic found;
        idle(3);
        rst = 1'b1;

        // LED store, then a non-strobed cycle must not write
        store(32'h1, 32'h0000_A5A5);
        check("led_write", {16'h0, led}, 32'h0000_A5A5);
        @(negedge clk);
        bepu_sel = 32'h1; bepu_data = '0; bepu_w = 1'b0;
        @(negedge clk);
        bepu_sel = '0;
        check("led_no_strobe", {16'h0, led}, 32'h0000_A5A5);

        // Hex display walk over a full scan
        store(32'h2, 32'h1234_ABCD);
        idle(34);

        // Blank digit 7, dp on digit 0
        store(32'h4, 32'h0000_0180);
        wait_an(8'h7F, found);
        check("dig7_seen", {31'h0, found}, 32'h1);
        check("dig7_blank", {24'h0, seg_cat}, 32'h0000_00FF);
        wait_an(8'hFE, found);
        check("dig0_seen", {31'h0, found}, 32'h1);
        check("dig0_dp_D", {24'h0, seg_cat}, 32'h0000_0021);
        store(32'h4, 32'h0);

        // Multi-select store hits LED and hex in the same cycle
        store(32'h3, 32'h0000_00FF);
        check("multi_led", {16'h0, led}, 32'h0000_00FF);
        wait_an(8'hFE, found);
        check("multi_dig0", {23'h0, found, seg_cat}, 32'h0000_018E);
        wait_an(8'hFD, found);
        check("multi_dig1", {23'h0, found, seg_cat}, 32'h0000_018E);

        // Hex store on the prescaler wrap edge
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            if ((n_m % SCAN_DIV) == SCAN_DIV - 1) found = 1'b1;
            else @(negedge clk);
        end
        check("wrap_phase_found", {31'h0, found}, 32'h1);
        bepu_sel = 32'h2; bepu_data = 32'h5555_5555; bepu_w = 1'b1;
        @(negedge clk);
        bepu_w = 1'b0; bepu_sel = '0; bepu_data = '0;
        @(negedge clk);
        check("wrap_new_digit", {24'h0, seg_cat}, 32'h0000_0092);

        // Asynchronous reset mid-scan after writes
        store(32'h7, 32'h0000_3C3C);
        idle(5);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_led", {16'h0, led}, 32'h0);
        check("async_rst_an",  {24'h0, seg_an}, 32'h0000_00FF);
        check("async_rst_cat", {24'h0, seg_cat}, 32'h0000_00FF);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_an0", {24'h0, seg_an}, 32'h0000_00FE);
        idle(10);

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            bepu_w    = 1'($urandom_range(0, 1));
            bepu_sel  = $urandom();
            bepu_data = $urandom();
            bepu_addr = $urandom();
            if ($urandom_range(0, 99) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        bepu_w = 1'b0;
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
